// File: rtl/mode_counter.sv
// -----------------------------------------------------------------------------
// mode_counter
//   Parametrised up/down counter with configurable step and modulus, and a
//   choice of modular wrap or saturation at the limits. It has synchronous
//   load, a count enable, direction control, a terminal-count flag and a
//   one-cycle wrap flag.
//
// Parameters
//   WIDTH    counter width in bits
//   INCR     step per enabled cycle (1 <= INCR <= MAX_VAL)
//   MAX_VAL  inclusive upper count limit (MAX_VAL <= 2**WIDTH-1)
//   SATURATE 0 = modular wrap, 1 = clip at 0 / MAX_VAL
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous reset, active-high
//   en       in   1      count enable
//   up       in   1      direction: 1 = up, 0 = down
//   load     in   1      synchronous load of data_in (priority over en)
//   data_in  in   WIDTH  load value, clamped to MAX_VAL
//   out      out  WIDTH  registered count
//   tc       out  1      terminal count, combinational from out and up
//   wrap     out  1      registered flag: last update wrapped or clipped
//   wrap_cnt out  8      saturating count of wrap cycles
//                        (present only with MODE_COUNTER_WRAPCNT_EN)
//
// Configuration macro
//   MODE_COUNTER_WRAPCNT_EN  adds the wrap_cnt port and its counter
// -----------------------------------------------------------------------------
module mode_counter #(
    parameter int WIDTH    = 5,
    parameter int INCR     = 1,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
`ifdef MODE_COUNTER_WRAPCNT_EN
    ,
    output logic [7:0]       wrap_cnt
`endif
);

    // All arithmetic is carried at WIDTH+1 bits so out + INCR and
    // MAX_VAL + 1 never overflow.
    localparam logic [WIDTH:0] C_MAX  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] C_LIM  = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH:0] C_INCR = (WIDTH+1)'(INCR);

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;

    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_up_wrap;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    assign w_ext     = {1'b0, r_out};
    assign w_sum     = w_ext + C_INCR;
    // Up overflow: only taken when w_sum > MAX_VAL, so the result is < INCR.
    assign w_up_wrap = WIDTH'(w_sum - C_LIM);
    assign w_dn      = WIDTH'(w_ext - C_INCR);
    // Down underflow: only taken when out < INCR, so (INCR - out) is positive
    // and the result stays below MAX_VAL+1.
    assign w_dn_wrap = WIDTH'(C_LIM - (C_INCR - w_ext));

    always_comb begin
        w_next = r_out;
        w_wrap = 1'b0;
        if (load) begin
            if ({1'b0, data_in} > C_MAX)
                w_next = C_MAX[WIDTH-1:0];
            else
                w_next = data_in;
        end else if (en) begin
            if (up) begin
                if (w_sum <= C_MAX) begin
                    w_next = w_sum[WIDTH-1:0];
                end else begin
                    w_wrap = 1'b1;
                    w_next = (SATURATE != 0) ? C_MAX[WIDTH-1:0] : w_up_wrap;
                end
            end else begin
                if (w_ext >= C_INCR) begin
                    w_next = w_dn;
                end else begin
                    w_wrap = 1'b1;
                    w_next = (SATURATE != 0) ? '0 : w_dn_wrap;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_out  <= w_next;
            r_wrap <= w_wrap;
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;
    assign tc   = up ? (w_ext == C_MAX) : (r_out == '0);

`ifdef MODE_COUNTER_WRAPCNT_EN
    logic [7:0] r_wrap_cnt;

    // Counts on the same edge that sets wrap, so wrap_cnt and wrap agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wrap_cnt <= 8'd0;
        else if (load)
            r_wrap_cnt <= 8'd0;
        else if (w_wrap && (r_wrap_cnt != 8'hFF))
            r_wrap_cnt <= r_wrap_cnt + 8'd1;
    end

    assign wrap_cnt = r_wrap_cnt;
`endif

endmodule
